// File: rtl/segasys1_sndcmd_queue.sv
// Main-CPU to sound-CPU command FIFO with edge-detected strobes and gapped NMI.
// Define SNDCMD_OVERWRITE_EN to drop the oldest entry on overflow instead of the newest.
module segasys1_sndcmd_queue #(
  parameter int DW      = 8,
  parameter int DEPTH   = 4,
  parameter int NMI_GAP = 16
) (
  input  logic                   CLK48M,
  input  logic                   RESET_N,
  input  logic                   WR_STB,
  input  logic [DW-1:0]          WR_DATA,
  input  logic                   SND_RD,
  output logic [DW-1:0]          SND_DO,
  output logic                   SND_NMI,
  output logic                   EMPTY,
  output logic                   FULL,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVF,
  input  logic                   CLR_OVF
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (NMI_GAP > 0) ? $clog2(NMI_GAP + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    GAP
  } state_t;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [DW-1:0] last;
  logic          wr_prev;
  logic          rd_prev;
  logic          ovf;
  state_t        state;
  state_t        state_d;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_d;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic ovf_set;
  logic mem_we;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign push    = WR_STB & ~wr_prev;
  assign pop     = SND_RD & ~rd_prev & ~empty;
  assign ovf_set = push & full & ~pop;

`ifdef SNDCMD_OVERWRITE_EN
  assign mem_we = RESET_N & push;
`else
  assign mem_we = RESET_N & push & (pop | ~full);
`endif

  always_ff @(posedge CLK48M) begin
    if (mem_we)
      mem[wr_ptr] <= WR_DATA;
  end

  always_ff @(posedge CLK48M) begin
    if (!RESET_N) begin
      wr_prev <= 1'b0;
      rd_prev <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      last    <= '1;
      ovf     <= 1'b0;
    end else begin
      wr_prev <= WR_STB;
      rd_prev <= SND_RD;
      if (push && pop) begin
        wr_ptr <= wr_ptr + AW'(1);
        rd_ptr <= rd_ptr + AW'(1);
        last   <= mem[rd_ptr];
      end else if (push && !full) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + CW'(1);
      end else if (push) begin
`ifdef SNDCMD_OVERWRITE_EN
        // Oldest entry is discarded silently; it never reaches the sound CPU.
        wr_ptr <= wr_ptr + AW'(1);
        rd_ptr <= rd_ptr + AW'(1);
`endif
      end else if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        count  <= count - CW'(1);
        last   <= mem[rd_ptr];
      end
      if (ovf_set)
        ovf <= 1'b1;
      else if (CLR_OVF)
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK48M) begin
    if (!RESET_N) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_d;
      gap_cnt <= gap_d;
    end
  end

  always_comb begin
    state_d = state;
    gap_d   = gap_cnt;
    unique case (state)
      IDLE: begin
        if (!empty)
          state_d = ASSERT;
      end
      ASSERT: begin
        if (pop) begin
          state_d = GAP;
          gap_d   = GW'(NMI_GAP);
        end
      end
      GAP: begin
        if (gap_cnt == '0)
          state_d = IDLE;
        else
          gap_d = gap_cnt - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign SND_DO  = empty ? last : mem[rd_ptr];
  assign SND_NMI = (state == ASSERT);
  assign EMPTY   = empty;
  assign FULL    = full;
  assign COUNT   = count;
  assign OVF     = ovf;

endmodule
